// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with 16x oversampling, sticky frame/overrun flags
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   rd         consumer acknowledge; clears data_valid, frame_err, overrun
//   data       last received byte
//   data_valid byte held and not yet acknowledged
//   frame_err  sticky, a stop bit was sampled low
//   overrun    sticky, a frame completed while data_valid was high
//   busy       receiver is not idle
module uart_receiver #(
  parameter int OVS_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DW = $clog2(OVS_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic [DW-1:0] r_div;
  logic [3:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic w_rx, w_tick, w_mid, w_data_smp, w_stop_smp;
  assign w_rx = r_sync[1];
  assign w_tick = r_div == DW'(OVS_DIV - 1);
  // START ends at the bit midpoint (8 ticks); DATA/STOP sample one bit period later (16 ticks)
  assign w_mid = w_tick & (r_state == START ? r_cnt == 4'd7 : r_cnt == 4'd15);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = (w_tick & ~w_rx) ? START : IDLE;
      START: w_next = w_mid ? (w_rx ? IDLE : DATA) : START;
      DATA:  w_next = (w_mid && r_bit == 3'd7) ? STOP : DATA;
      STOP:  w_next = w_mid ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    w_data_smp = w_mid & (r_state == DATA);
    w_stop_smp = w_mid & (r_state == STOP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= 2'b11;
      r_div <= '0;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh <= '0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_div <= w_tick ? '0 : r_div + 1'b1;
      r_cnt <= (r_state == IDLE || w_mid) ? 4'd0 : w_tick ? r_cnt + 4'd1 : r_cnt;
      r_bit <= (r_state == IDLE) ? 3'd0 : w_data_smp ? r_bit + 3'd1 : r_bit;
      r_sh <= w_data_smp ? {w_rx, r_sh[7:1]} : r_sh;
    end
  // a stop sample coinciding with rd wins: flags then reflect only the new frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data <= 8'h00;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      data <= w_stop_smp ? r_sh : data;
      data_valid <= w_stop_smp | (data_valid & ~rd);
      frame_err <= (frame_err & ~rd) | (w_stop_smp & ~w_rx);
      overrun <= (overrun & ~rd) | (w_stop_smp & data_valid & ~rd);
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVS_DIV, default 8: clk cycles per oversample tick; bit period = 16*OVS_DIV clk cycles (128 at default).
REQ-002 Parameter OVS_DIV SHALL be an integer >= 2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rd  input  1  consumer acknowledge; clears data_valid.
REQ-007 data  output  8  last received byte, LSB first on the line.
REQ-008 data_valid  output  1  level; a byte is held in data and not yet acknowledged.
REQ-009 frame_err  output  1  sticky; the stop bit of a completed frame was sampled low.
REQ-010 overrun  output  1  sticky; a frame completed while data_valid was high.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use; latency 2 clk.
REQ-013 The oversample tick SHALL be a 1-clk pulse every OVS_DIV clk, from a free-running counter that wraps OVS_DIV-1 -> 0.
REQ-014 FSM states: IDLE, START, DATA, STOP. All transitions are synchronous to clk and qualified by tick.
REQ-015 IDLE: the 4-bit sample counter is held at 0; a synchronized rx==0 seen on a tick SHALL go to START.
REQ-016 START: count 8 ticks to the bit midpoint; rx==0 there -> DATA with sample counter 0; rx==1 there (glitch) -> IDLE with no output change.
REQ-017 DATA: sample rx every 16 ticks; shift into an 8-bit register from the MSB end (LSB arrives first); 3-bit bit counter; after the 8th sample -> STOP.
REQ-018 STOP: sample rx 16 ticks after the last data sample, then return to IDLE on the same clk.
REQ-019 At the stop sample: data <= shift register; data_valid <= 1; frame_err <= frame_err | ~rx; overrun <= overrun | data_valid (value before this update).
REQ-020 A byte with a bad stop bit SHALL still be delivered and flagged.
REQ-021 rd==1 SHALL clear data_valid on the next clk; frame_err and overrun SHALL also clear on rd.
REQ-022 Simultaneous rd and stop-sample update in the same clk: the new byte wins; data_valid=1, overrun not set, flags reflect the new frame only.
REQ-023 data SHALL be stable whenever data_valid==1, except when overwritten under REQ-019.
REQ-024 Back-to-back frames: a start edge that arrives immediately after the stop sample SHALL be accepted, with no idle bit required beyond the stop sample point.
REQ-025 Latency: data_valid rises within 2 clk + 1 tick of the nominal stop-bit midpoint.

Reset
REQ-026 On rst: state=IDLE; all counters=0; synchronizer flops=1; data=8'h00; data_valid=0; frame_err=0; overrun=0; busy=0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no partial byte delivered; reception resumes at the next falling edge after release.

Verification
REQ-028 OVS_DIV=8; send 0xA5 with 8N1, bit=128 clk -> data=0xA5 and data_valid=1 about 1216 clk after the start edge; frame_err=0.
REQ-029 Send 0x3C without rd, then 0x81 -> data=0x81, data_valid=1, overrun=1; pulse rd -> data_valid=0, overrun=0.
REQ-030 Send 0x55 with stop bit held low -> data=0x55, frame_err=1, data_valid=1; then hold rx high -> no further frame.
REQ-031 Drive rx low for 40 clk, then high -> busy pulses, returns to IDLE, data_valid stays 0.
REQ-032 Assert rst at bit 4 of 0xFF, release, send 0x12 -> only 0x12 is delivered; no stale bits.
REQ-033 Send 0x00 then 0xFF back-to-back, pulsing rd in the clk each byte lands -> both bytes received in order, overrun=0.
